// File: rtl/reg_bank_bypass.sv
// reg_bank_bypass
//   A bank of DEPTH registers, each WIDTH bits wide. It has one byte-enabled
//   write port and two registered read ports. A read that hits the address
//   being written in the same cycle returns the post-write data.
//   Entry 0 can be hardwired to zero. A dirty mask records which entries were
//   written since the last dirty_clr.
//
// Ports
//   clk                 rising-edge clock
//   clr                 synchronous active-high reset (highest priority)
//   wen/waddr/wdata/wbe write port; wbe[i] covers wdata[8i+7:8i]
//   ren_a/raddr_a       read request, port A
//   rdata_a/rvalid_a    registered read data and one-cycle valid pulse, port A
//   ren_b/raddr_b       read request, port B
//   rdata_b/rvalid_b    registered read data and one-cycle valid pulse, port B
//   dirty_clr           clears the dirty mask (a same-cycle write still marks)
//   dirty               bit n set = entry n written since last clear
module reg_bank_bypass #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 wen,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic                 ren_a,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [WIDTH-1:0]     rdata_a,
  output logic                 rvalid_a,
  input  logic                 ren_b,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [WIDTH-1:0]     rdata_b,
  output logic                 rvalid_b,
  input  logic                 dirty_clr,
  output logic [DEPTH-1:0]     dirty
);

  localparam int NBYTES = WIDTH / 8;
  // With a power-of-two depth every address is in range, so no compare is needed.
  localparam bit POW2 = (DEPTH == (1 << ADDR_W));

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] dirty_reg;
  logic [DEPTH-1:0] dirty_next;

  logic             waddr_ok;
  logic             wr_eff;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [DEPTH-1:0] wr_onehot;

  generate
    if (POW2) begin : g_wpow2
      assign waddr_ok = 1'b1;
    end else begin : g_wnpow2
      assign waddr_ok = (waddr < ADDR_W'(DEPTH));
    end
  endgenerate

  // A write with no byte enables, to an out-of-range address, or to the
  // hardwired zero entry changes nothing, not even the dirty mask.
  assign wr_eff = wen && !clr && waddr_ok && (|wbe) &&
                  !((ZERO_REG != 0) && (waddr == '0));

  assign wr_old = waddr_ok ? mem_reg[waddr] : '0;

  // The post-write word is shared by the storage update and the read bypass,
  // so both always agree.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign wr_merged[gi*8 +: 8] = wbe[gi] ? wdata[gi*8 +: 8] : wr_old[gi*8 +: 8];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign wr_onehot[gi] = wr_eff && (waddr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr) begin
        mem_reg[i] <= '0;
      end else if (wr_onehot[i]) begin
        mem_reg[i] <= wr_merged;
      end
    end
  end

  // dirty_clr with a same-cycle write leaves only the written bit set.
  always_comb begin
    dirty_next = dirty_reg | wr_onehot;
    if (clr) begin
      dirty_next = '0;
    end else if (dirty_clr) begin
      dirty_next = wr_onehot;
    end
  end

  always_ff @(posedge clk) begin
    dirty_reg <= dirty_next;
  end

  assign dirty = dirty_reg;

  // Both read ports are identical. Pack their inputs so that one generate
  // loop builds them.
  logic [1:0]        ren_p;
  logic [ADDR_W-1:0] raddr_p [2];

  assign ren_p      = {ren_b, ren_a};
  assign raddr_p[0] = raddr_a;
  assign raddr_p[1] = raddr_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic             raddr_ok;
      logic             rd_zero;
      logic [WIDTH-1:0] rd_word;
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;

      if (POW2) begin : g_rpow2
        assign raddr_ok = 1'b1;
      end else begin : g_rnpow2
        assign raddr_ok = (raddr_p[gi] < ADDR_W'(DEPTH));
      end

      assign rd_zero = !raddr_ok || ((ZERO_REG != 0) && (raddr_p[gi] == '0));
      assign rd_word = rd_zero ? '0 :
                       (wr_eff && (raddr_p[gi] == waddr)) ? wr_merged :
                       mem_reg[raddr_p[gi]];

      always_ff @(posedge clk) begin
        if (clr) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= ren_p[gi];
          if (ren_p[gi]) begin
            data_reg <= rd_word;
          end
        end
      end
    end
  endgenerate

  assign rdata_a  = g_rd[0].data_reg;
  assign rvalid_a = g_rd[0].valid_reg;
  assign rdata_b  = g_rd[1].data_reg;
  assign rvalid_b = g_rd[1].valid_reg;

endmodule

// File: tb/tb_reg_bank_bypass.sv
// Directed testbench for reg_bank_bypass.
//   u_dut  : default build (DEPTH=16, ZERO_REG=1)
//   u_dut0 : DEPTH=12, ZERO_REG=0 (exercises the ordinary entry 0 and
//            out-of-range addresses). It shares all inputs with u_dut.
module tb_reg_bank_bypass;

  logic        clk = 1'b0;
  logic        clr, wen, ren_a, ren_b, dirty_clr;
  logic [3:0]  waddr, raddr_a, raddr_b, wbe;
  logic [31:0] wdata;

  logic [31:0] rdata_a, rdata_b, rdata_a0, rdata_b0;
  logic        rvalid_a, rvalid_b, rvalid_a0, rvalid_b0;
  logic [15:0] dirty;
  logic [11:0] dirty0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_bank_bypass #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1)) u_dut (
    .clk(clk), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .dirty_clr(dirty_clr), .dirty(dirty)
  );

  reg_bank_bypass #(.WIDTH(32), .DEPTH(12), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .dirty_clr(dirty_clr), .dirty(dirty0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clr = 0; wen = 0; waddr = 0; wdata = 0; wbe = 0;
    ren_a = 0; raddr_a = 0; ren_b = 0; raddr_b = 0; dirty_clr = 0;
  endtask

  // Apply the current inputs on one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wen = 1; waddr = a; wdata = d; wbe = be;
  endtask

  initial begin
    idle();
    clr = 1;
    step();

    // Arbitrary writes, then a two-cycle clear
    idle(); wr(4'd7, 32'hAAAA5555, 4'hF); step();
    idle(); wr(4'd9, 32'h12345678, 4'hF); step();
    idle(); clr = 1; step(); step();
    $display("clr x2 after writes: rdata_a=%h rvalid_a=%b dirty=%h", rdata_a, rvalid_a, dirty);
    chk("rst_rdata_a",  rdata_a,  32'h0);
    chk("rst_rdata_b",  rdata_b,  32'h0);
    chk("rst_rvalid_a", {31'b0, rvalid_a}, 32'h0);
    chk("rst_rvalid_b", {31'b0, rvalid_b}, 32'h0);
    chk("rst_dirty",    {16'b0, dirty}, 32'h0);
    chk("rst_dirty0",   {20'b0, dirty0}, 32'h0);

    // Every entry reads zero after the clear
    for (int i = 1; i < 16; i++) begin
      idle(); ren_a = 1; raddr_a = 4'(i); step();
      $display("read after clr: addr=%0d rdata_a=%h rvalid_a=%b", i, rdata_a, rvalid_a);
      chk($sformatf("rst_read_%0d", i), rdata_a, 32'h0);
      chk($sformatf("rst_rvld_%0d", i), {31'b0, rvalid_a}, 32'h1);
    end

    // Full write, then read one cycle later
    idle(); wr(4'd5, 32'hDEADBEEF, 4'hF); step();
    idle(); ren_a = 1; raddr_a = 5; step();
    $display("read 5: rdata_a=%h rvalid_a=%b dirty=%h", rdata_a, rvalid_a, dirty);
    chk("rd5_data",   rdata_a, 32'hDEADBEEF);
    chk("rd5_valid",  {31'b0, rvalid_a}, 32'h1);
    chk("rd5_dirty",  {16'b0, dirty}, 32'h0020);
    chk("rd5_dirty0", {20'b0, dirty0}, 32'h020);
    idle(); step();
    $display("idle: rdata_a=%h rvalid_a=%b", rdata_a, rvalid_a);
    chk("hold_data",  rdata_a, 32'hDEADBEEF);
    chk("hold_valid", {31'b0, rvalid_a}, 32'h0);

    // Byte-enabled write with same-cycle reads on both ports (bypass)
    idle(); wr(4'd5, 32'h11223344, 4'b0101);
    ren_b = 1; raddr_b = 5; ren_a = 1; raddr_a = 5; step();
    $display("bypass: rdata_a=%h rdata_b=%h rvalid_b=%b", rdata_a, rdata_b, rvalid_b);
    chk("byp_b",     rdata_b, 32'hDE22BE44);
    chk("byp_b_vld", {31'b0, rvalid_b}, 32'h1);
    chk("byp_a",     rdata_a, 32'hDE22BE44);
    idle(); ren_a = 1; raddr_a = 5; step();
    $display("reread 5: rdata_a=%h", rdata_a);
    chk("reread5", rdata_a, 32'hDE22BE44);

    // Writes to address 0: hardwired zero vs ordinary entry
    idle(); wr(4'd0, 32'hFFFFFFFF, 4'hF); ren_a = 1; raddr_a = 0; step();
    $display("w0 bypass: rdata_a=%h rdata_a0=%h", rdata_a, rdata_a0);
    chk("z_byp",  rdata_a,  32'h0);
    chk("nz_byp", rdata_a0, 32'hFFFFFFFF);
    idle(); ren_a = 1; raddr_a = 0; step();
    $display("read 0: rdata_a=%h rdata_a0=%h dirty=%h dirty0=%h", rdata_a, rdata_a0, dirty, dirty0);
    chk("z_rd0",    rdata_a,  32'h0);
    chk("nz_rd0",   rdata_a0, 32'hFFFFFFFF);
    chk("z_dirty",  {16'b0, dirty}, 32'h0020);
    chk("nz_dirty", {20'b0, dirty0}, 32'h021);

    // Dirty mask: clear, build 0x00F0, then clear together with a write
    idle(); dirty_clr = 1; step();
    chk("dclr0", {16'b0, dirty}, 32'h0);
    for (int i = 4; i < 8; i++) begin
      idle(); wr(4'(i), 32'(i), 4'hF); step();
    end
    $display("dirty after writes 4..7: %h", dirty);
    chk("dirty_f0", {16'b0, dirty}, 32'h00F0);
    idle(); dirty_clr = 1; wr(4'd3, 32'h33, 4'hF); step();
    $display("dirty_clr + write 3: %h", dirty);
    chk("dclr_wr", {16'b0, dirty}, 32'h0008);
    idle(); dirty_clr = 1; step();
    $display("dirty_clr alone: %h", dirty);
    chk("dclr_alone", {16'b0, dirty}, 32'h0);

    // wen with no byte enables is not a write
    idle(); wr(4'd9, 32'hCAFEF00D, 4'b0000); ren_b = 1; raddr_b = 9; step();
    $display("wbe=0 write 9: rdata_b=%h dirty=%h", rdata_b, dirty);
    chk("wbe0_byp",   rdata_b, 32'h0);
    chk("wbe0_dirty", {16'b0, dirty}, 32'h0);
    idle(); ren_b = 1; raddr_b = 9; step();
    chk("wbe0_rd", rdata_b, 32'h0);

    // Out-of-range write and read on the DEPTH=12 instance
    idle(); dirty_clr = 1; step();
    idle(); wr(4'd13, 32'h0BADBAD0, 4'hF); ren_b = 1; raddr_b = 13; step();
    $display("oor: rdata_b0=%h rvalid_b0=%b dirty0=%h", rdata_b0, rvalid_b0, dirty0);
    chk("oor_byp",   rdata_b0, 32'h0);
    chk("oor_vld",   {31'b0, rvalid_b0}, 32'h1);
    chk("oor_dirty", {20'b0, dirty0}, 32'h0);
    chk("in_dirty",  {16'b0, dirty}, 32'h2000);

    // Back-to-back writes 1,2,3 with clr on the third
    idle(); wr(4'd1, 32'd1, 4'hF); step();
    idle(); wr(4'd2, 32'd2, 4'hF); step();
    idle(); wr(4'd3, 32'd3, 4'hF); clr = 1; ren_a = 1; raddr_a = 3; step();
    $display("clr on write 3: dirty=%h rvalid_a=%b", dirty, rvalid_a);
    chk("b2b_dirty", {16'b0, dirty}, 32'h0);
    chk("b2b_rvld",  {31'b0, rvalid_a}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      idle(); ren_a = 1; raddr_a = 4'(i); ren_b = 1; raddr_b = 4'(i); step();
      $display("b2b read %0d: rdata_a=%h rdata_b0=%h", i, rdata_a, rdata_b0);
      chk($sformatf("b2b_rd_%0d", i),  rdata_a,  32'h0);
      chk($sformatf("b2b_rd0_%0d", i), rdata_b0, 32'h0);
    end
    chk("b2b_dirty_end", {16'b0, dirty}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
